// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and constants for the data memory controller: FSM encoding, opcode bits, word width.
// Pure declarations; no timing or flow-control behaviour lives here.
package data_memory_ctrl_pkg;

    localparam int WORD_W    = 32;
    localparam int OP_W      = 2;
    localparam int OP_RD_BIT = 0;
    localparam int OP_WR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when no address bit above the word index is set
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int idx_w);
        return (addr >> (idx_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// CPU-side request/response bundle of the data memory controller.
// Level request held by the CPU; completion and rejection come back as single-cycle pulses.
interface data_memory_ctrl_if;
    import data_memory_ctrl_pkg::*;

    logic              memRead;
    logic              memWrite;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_busy;
    logic              mem_error;

    modport master (
        output memRead, memWrite, address, write_data,
        input  read_data, mem_ready, mem_busy, mem_error
    );

    modport slave (
        input  memRead, memWrite, address, write_data,
        output read_data, mem_ready, mem_busy, mem_error
    );

endinterface

// File: rtl/data_memory_ctrl_mem_latency_counter.sv
// Down-counter timing the busy phase of a memory access; loads, decrements, flags zero.
// One register stage; no flow control, the owning FSM decides when to load and decrement.
module mem_latency_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the count being at zero, or stepping onto zero at the coming edge
    assign zero_o = (count_q == '0) || (dec_i && (count_q == CNT_W'(1)));

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory: accepts one load/store in IDLE, completes it LATENCY cycles later.
// mem_busy covers the whole access including the mem_ready cycle; requests outside IDLE are ignored.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_ctrl_if.slave  mem
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [IDX_W-1:0]  idx;
        logic [1:0]        off;
        logic [WORD_W-1:0] wdata;
    } req_t;

    state_e            state_q;
    state_e            state_d;
    req_t              req_q;
    req_t              req_d;
    req_t              req_in;
    req_t              req_eff;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] read_data_q;
    logic [WORD_W-1:0] read_data_d;
    logic              error_q;
    logic              error_d;

    logic any_req;
    logic reject;
    logic valid_req;
    logic accept;
    logic enter_done;
    logic cnt_dec;
    logic cnt_zero;
    logic rd_commit;
    logic wr_commit;

    assign any_req   = mem.memRead | mem.memWrite;
    assign reject    = any_req && ((mem.memRead && mem.memWrite)
                                   || (mem.address[1:0] != 2'b00)
                                   || !addr_in_range(mem.address, IDX_W));
    assign valid_req = any_req && !reject;

    always_comb begin
        req_in                = '0;
        req_in.op[OP_RD_BIT]  = mem.memRead;
        req_in.op[OP_WR_BIT]  = mem.memWrite;
        req_in.idx            = mem.address[IDX_W+1:2];
        req_in.off            = mem.address[1:0];
        req_in.wdata          = mem.write_data;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        req_eff    = req_q;
        accept     = 1'b0;
        enter_done = 1'b0;
        cnt_dec    = 1'b0;
        error_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // With a one-cycle latency the access commits on the accepting edge itself
                req_eff = req_in;
                error_d = reject;
                if (valid_req) begin
                    accept = 1'b1;
                    req_d  = req_in;
                    if (LATENCY == 1) begin
                        state_d    = ST_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mem_latency_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign rd_commit   = enter_done && req_eff.op[OP_RD_BIT];
    assign wr_commit   = enter_done && req_eff.op[OP_WR_BIT] && (req_eff.off == 2'b00);
    assign read_data_d = rd_commit ? mem_q[req_eff.idx] : read_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            read_data_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            read_data_q <= read_data_d;
            error_q     <= error_d;
        end
    end

    // Storage is never cleared; reset only blocks an in-flight store from landing
    always_ff @(posedge clk) begin
        if (!reset && wr_commit) begin
            mem_q[req_eff.idx] <= req_eff.wdata;
        end
    end

    assign mem.read_data = read_data_q;
    assign mem.mem_ready = (state_q == ST_DONE);
    assign mem.mem_busy  = (state_q != ST_IDLE);
    assign mem.mem_error = error_q;

endmodule
